// File: rtl/port_pattern_gen.sv
// rtl/port_pattern_gen.sv - command-driven generated-frame responder on the 8-bit sof/eof port protocol
// PATTERN_LFSR_EN selects an 8-bit LFSR data pattern instead of the incrementing SEED+i pattern.
module port_pattern_gen #(
  parameter int unsigned MAX_LEN    = 1514,
  parameter logic [7:0]  CMD_OPCODE = 8'h01
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wen,
  input  logic       ren,
  input  logic [7:0] in_data,
  input  logic       in_sof,
  input  logic       in_eof,
  input  logic       in_src_rdy,
  output logic       in_dst_rdy,
  output logic [7:0] out_data,
  output logic       out_sof,
  output logic       out_eof,
  output logic       out_src_rdy,
  input  logic       out_dst_rdy,
  output logic       busy
);

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_DRAIN, S_DECIDE, S_GEN} state_t;

  localparam logic [15:0] MAX_LEN16 = 16'(MAX_LEN);

  state_t      r_state;
  logic        r_in_rdy;
  logic [7:0]  r_op;
  logic [15:0] r_len;
  logic [7:0]  r_seed;
  logic [1:0]  r_idx;
  logic [15:0] r_cnt;
  logic [7:0]  r_data;
  logic        r_sof;
  logic        r_eof;

  logic        w_in_beat;
  logic        w_out_beat;
  logic [15:0] w_eff_len;
  logic [7:0]  w_first;
  logic [7:0]  w_next;

  assign w_in_beat  = in_src_rdy & in_dst_rdy;
  assign w_out_beat = out_src_rdy & out_dst_rdy;
  assign w_eff_len  = (r_len > MAX_LEN16) ? MAX_LEN16 : r_len;

`ifdef PATTERN_LFSR_EN
  // Fibonacci LFSR x^8+x^6+x^5+x^4+1; an all-zero seed would lock up, so it starts at FF.
  assign w_first = (r_seed == 8'h00) ? 8'hFF : r_seed;
  assign w_next  = {r_data[6:0], r_data[7] ^ r_data[5] ^ r_data[4] ^ r_data[3]};
`else
  assign w_first = r_seed;
  assign w_next  = r_data + 8'd1;
`endif

  // r_in_rdy is a register so in_dst_rdy stays low while reset is held.
  assign in_dst_rdy  = wen & r_in_rdy;
  assign out_src_rdy = (r_state == S_GEN) & ren;
  assign busy        = (r_state == S_GEN);
  assign out_data    = r_data;
  assign out_sof     = r_sof;
  assign out_eof     = r_eof;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_in_rdy <= 1'b0;
      r_op     <= 8'd0;
      r_len    <= 16'd0;
      r_seed   <= 8'd0;
      r_idx    <= 2'd0;
      r_cnt    <= 16'd0;
      r_data   <= 8'd0;
      r_sof    <= 1'b0;
      r_eof    <= 1'b0;
    end else begin
      r_in_rdy <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_in_beat && in_sof) begin
            r_op  <= in_data;
            r_idx <= 2'd1;
            if (!in_eof) r_state <= S_CMD;
          end
        end
        S_CMD: begin
          if (w_in_beat) begin
            if (in_sof) begin
              r_op  <= in_data;
              r_idx <= 2'd1;
              if (in_eof) r_state <= S_IDLE;
            end else begin
              case (r_idx)
                2'd1:    r_len[15:8] <= in_data;
                2'd2:    r_len[7:0]  <= in_data;
                default: r_seed      <= in_data;
              endcase
              r_idx <= r_idx + 2'd1;
              if (r_idx == 2'd3) begin
                r_state <= in_eof ? S_DECIDE : S_DRAIN;
                if (in_eof) r_in_rdy <= 1'b0;
              end else if (in_eof) begin
                r_state <= S_IDLE;
              end
            end
          end
        end
        S_DRAIN: begin
          if (w_in_beat && in_eof) begin
            r_state  <= S_DECIDE;
            r_in_rdy <= 1'b0;
          end
        end
        S_DECIDE: begin
          if (r_op != CMD_OPCODE || r_len == 16'd0) begin
            r_state <= S_IDLE;
          end else begin
            r_state  <= S_GEN;
            r_in_rdy <= 1'b0;
            r_len    <= w_eff_len;
            r_cnt    <= 16'd0;
            r_data   <= w_first;
            r_sof    <= 1'b1;
            r_eof    <= (w_eff_len == 16'd1);
          end
        end
        S_GEN: begin
          r_in_rdy <= 1'b0;
          if (w_out_beat) begin
            if (r_eof) begin
              r_state  <= S_IDLE;
              r_in_rdy <= 1'b1;
              r_sof    <= 1'b0;
              r_eof    <= 1'b0;
            end else begin
              r_cnt  <= r_cnt + 16'd1;
              r_data <= w_next;
              r_sof  <= 1'b0;
              r_eof  <= (r_cnt + 16'd2 == r_len);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_port_pattern_gen.sv
// tb/tb_port_pattern_gen.sv - randomized self-checking bench for port_pattern_gen against a frame-level model
module tb_port_pattern_gen;
  logic       clk = 1'b0;
  logic       rst, wen, ren, in_sof, in_eof, in_src_rdy, out_dst_rdy;
  logic [7:0] in_data;
  logic       in_dst_rdy, out_sof, out_eof, out_src_rdy, busy;
  logic [7:0] out_data;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  logic [7:0] cmd_q[$];
  logic [9:0] got_q[$];
  logic [9:0] exp_q[$];
  int first_valid_cyc = -1;
  int eof_beat_cyc    = -1;
  int rdy_ret_cyc     = -1;
  int hold_err        = 0;
  int rdy_leak        = 0;
  int fc_mode         = 0;
  int fc_k            = 0;
  logic       prev_busy = 1'b0;
  logic       prev_beat = 1'b0;
  logic [9:0] prev_word = 10'd0;

  port_pattern_gen dut (
    .clk(clk), .rst(rst), .wen(wen), .ren(ren),
    .in_data(in_data), .in_sof(in_sof), .in_eof(in_eof),
    .in_src_rdy(in_src_rdy), .in_dst_rdy(in_dst_rdy),
    .out_data(out_data), .out_sof(out_sof), .out_eof(out_eof),
    .out_src_rdy(out_src_rdy), .out_dst_rdy(out_dst_rdy), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc++;
    #1;
    if (fc_mode == 1) begin
      out_dst_rdy = 1'($urandom_range(0, 1));
      ren         = ($urandom_range(0, 3) != 0);
    end else if (fc_mode == 2) begin
      fc_k++;
      out_dst_rdy = fc_k[0];
      ren         = !(fc_k >= 10 && fc_k < 13);
    end
  end

  always @(negedge clk) begin : mon
    logic [9:0] w;
    w = {out_sof, out_eof, out_data};
    if (rst !== 1'b0) begin
      prev_busy = 1'b0;
      prev_beat = 1'b0;
    end else begin
      if (busy && in_dst_rdy) rdy_leak++;
      if (busy && prev_busy && !prev_beat && w !== prev_word) hold_err++;
      if (out_src_rdy && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (out_src_rdy && out_dst_rdy) begin
        got_q.push_back(w);
        if (out_eof) begin
          eof_beat_cyc = cyc;
          rdy_ret_cyc  = -1;
        end
      end
      if (in_dst_rdy && eof_beat_cyc >= 0 && rdy_ret_cyc < 0 && cyc > eof_beat_cyc) rdy_ret_cyc = cyc;
      prev_busy = busy;
      prev_beat = out_src_rdy && out_dst_rdy;
      prev_word = w;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1);
  end

  // Expected frame straight from the command rules: {sof, eof, data} per byte.
  function automatic void build_exp(input logic [7:0] op, input int len, input logic [7:0] seed);
    int l;
    logic [7:0] d;
    exp_q.delete();
    if (op != 8'h01 || len == 0) return;
    l = (len > 1514) ? 1514 : len;
    d = seed;
`ifdef PATTERN_LFSR_EN
    if (d == 8'h00) d = 8'hFF;
`endif
    for (int i = 0; i < l; i++) begin
`ifdef PATTERN_LFSR_EN
      if (i > 0) d = {d[6:0], ^(d & 8'hB8)};
`else
      d = 8'((int'(seed) + i) % 256);
`endif
      exp_q.push_back({1'(i == 0), 1'(i == l - 1), d});
    end
  endfunction

  function automatic logic [9:0] got_at(input int i);
    return (i >= 0 && i < got_q.size()) ? got_q[i] : 10'bx;
  endfunction

  function automatic logic [9:0] exp_at(input int i);
    return (i >= 0 && i < exp_q.size()) ? exp_q[i] : 10'bx;
  endfunction

  function automatic int first_diff();
    int n;
    n = (got_q.size() > exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) if (got_at(i) !== exp_at(i)) return i;
    return -1;
  endfunction

  task automatic clear_mon();
    got_q.delete();
    first_valid_cyc = -1;
    eof_beat_cyc    = -1;
    rdy_ret_cyc     = -1;
    rdy_leak        = 0;
    hold_err        = 0;
  endtask

  task automatic send_frame(output int eof_c);
    int guard;
    eof_c = -1;
    for (int i = 0; i < cmd_q.size(); i++) begin
      @(posedge clk); #1;
      in_src_rdy = 1'b1;
      in_data    = cmd_q[i];
      in_sof     = (i == 0);
      in_eof     = (i == cmd_q.size() - 1);
      guard = 0;
      while (!in_dst_rdy && guard < 5000) begin
        @(posedge clk); #1;
        guard++;
      end
      if (guard >= 5000) begin
        $display("FAIL send_timeout: in_dst_rdy got 0 expected 1 within 5000 cycles");
        $fatal(1);
      end
      if (i == cmd_q.size() - 1) eof_c = cyc;
    end
    @(posedge clk); #1;
    in_src_rdy = 1'b0;
    in_sof     = 1'b0;
    in_eof     = 1'b0;
  endtask

  task automatic wait_done(input int n);
    int g;
    g = 0;
    repeat (4) @(posedge clk);
    while ((got_q.size() < n || busy) && g < 4000) begin
      @(posedge clk);
      g++;
    end
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (g >= 4000) $display("FAIL wait_done: got %0d bytes expected %0d before timeout", got_q.size(), n);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1; wen = 1'b1; ren = 1'b1; out_dst_rdy = 1'b1;
    in_src_rdy = 1'b0; in_sof = 1'b0; in_eof = 1'b0; in_data = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({in_dst_rdy, out_src_rdy, out_sof, out_eof, busy, out_data} !== 13'd0)
      $display("FAIL reset_outputs: got %h expected 0", {in_dst_rdy, out_src_rdy, out_sof, out_eof, busy, out_data});
    else n_pass++;
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (in_dst_rdy !== 1'b1) $display("FAIL reset_release_rdy: got %b expected 1", in_dst_rdy);
    else n_pass++;
  endtask

  task automatic test_basic();
    int eof_c, d;
    logic [9:0] w;
    fc_mode = 0; ren = 1'b1; out_dst_rdy = 1'b1;
    cmd_q = '{8'h01, 8'h00, 8'h05, 8'h10};
    build_exp(8'h01, 5, 8'h10);
    clear_mon();
    send_frame(eof_c);
    wait_done(exp_q.size());
    d = first_diff();
    n_checks++;
    if (d >= 0) $display("FAIL basic_frame: byte %0d got %h expected %h", d, got_at(d), exp_at(d));
    else n_pass++;
    n_checks++;
    if (first_valid_cyc - eof_c !== 2) $display("FAIL basic_latency: got %0d expected 2", first_valid_cyc - eof_c);
    else n_pass++;
    n_checks++;
    if (eof_beat_cyc - first_valid_cyc !== 4) $display("FAIL basic_stream: got %0d expected 4", eof_beat_cyc - first_valid_cyc);
    else n_pass++;
    n_checks++;
    if (rdy_ret_cyc - eof_beat_cyc !== 1) $display("FAIL basic_rdy_return: got %0d expected 1", rdy_ret_cyc - eof_beat_cyc);
    else n_pass++;
`ifndef PATTERN_LFSR_EN
    w = got_at(0);
    n_checks++;
    if (w !== 10'h210) $display("FAIL basic_first: got %h expected 210", w);
    else n_pass++;
    w = got_at(4);
    n_checks++;
    if (w !== 10'h114) $display("FAIL basic_last: got %h expected 114", w);
    else n_pass++;
`endif
  endtask

  task automatic test_wrap_max();
    int eof_c, d;
    logic [9:0] w;
    cmd_q = '{8'h01, 8'hFF, 8'hFF, 8'hFE};
    build_exp(8'h01, 65535, 8'hFE);
    clear_mon();
    send_frame(eof_c);
    wait_done(1514);
    n_checks++;
    if (got_q.size() !== 1514) $display("FAIL max_len: got %0d expected 1514", got_q.size());
    else n_pass++;
    d = first_diff();
    n_checks++;
    if (d >= 0) $display("FAIL max_frame: byte %0d got %h expected %h", d, got_at(d), exp_at(d));
    else n_pass++;
    w = got_at(1513);
    n_checks++;
    if (w[8] !== 1'b1) $display("FAIL max_eof: got %b expected 1", w[8]);
    else n_pass++;
`ifndef PATTERN_LFSR_EN
    w = got_at(1);
    n_checks++;
    if (w[7:0] !== 8'hFF) $display("FAIL wrap_byte1: got %h expected ff", w[7:0]);
    else n_pass++;
    w = got_at(2);
    n_checks++;
    if (w[7:0] !== 8'h00) $display("FAIL wrap_byte2: got %h expected 00", w[7:0]);
    else n_pass++;
`endif
  endtask

  task automatic test_single_and_reject();
    int eof_c, d;
    cmd_q = '{8'h01, 8'h00, 8'h01, 8'hAA};
    build_exp(8'h01, 1, 8'hAA);
    clear_mon();
    send_frame(eof_c);
    wait_done(exp_q.size());
    d = first_diff();
    n_checks++;
    if (d >= 0) $display("FAIL single_frame: byte %0d got %h expected %h", d, got_at(d), exp_at(d));
    else n_pass++;
    for (int k = 0; k < 2; k++) begin
      if (k == 0) cmd_q = '{8'h02, 8'h00, 8'h04, 8'h00};
      else        cmd_q = '{8'h01, 8'h00, 8'h00, 8'h00};
      clear_mon();
      send_frame(eof_c);
      n_checks++;
      if (in_dst_rdy !== 1'b0) $display("FAIL reject_decide_rdy%0d: got %b expected 0", k, in_dst_rdy);
      else n_pass++;
      @(posedge clk); #1;
      n_checks++;
      if (in_dst_rdy !== 1'b1) $display("FAIL reject_rdy_back%0d: got %b expected 1", k, in_dst_rdy);
      else n_pass++;
      repeat (10) @(posedge clk);
      #1;
      n_checks++;
      if (got_q.size() !== 0) $display("FAIL reject_no_output%0d: got %0d bytes expected 0", k, got_q.size());
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    int eof_c, d;
    cmd_q = '{8'h01, 8'h00, 8'h08, 8'h00};
    build_exp(8'h01, 8, 8'h00);
    clear_mon();
    fc_k = 0; fc_mode = 2;
    send_frame(eof_c);
    wait_done(exp_q.size());
    fc_mode = 0; ren = 1'b1; out_dst_rdy = 1'b1;
    d = first_diff();
    n_checks++;
    if (d >= 0) $display("FAIL bp_frame: byte %0d got %h expected %h", d, got_at(d), exp_at(d));
    else n_pass++;
    n_checks++;
    if (rdy_leak !== 0) $display("FAIL bp_in_rdy_gen: got %0d cycles expected 0", rdy_leak);
    else n_pass++;
    n_checks++;
    if (hold_err !== 0) $display("FAIL bp_hold: got %0d changes expected 0", hold_err);
    else n_pass++;
  endtask

  task automatic test_abort_then_valid();
    int eof_c, d;
    cmd_q = '{8'h01, 8'h00, 8'h04};
    clear_mon();
    send_frame(eof_c);
    n_checks++;
    if (in_dst_rdy !== 1'b1) $display("FAIL abort_rdy: got %b expected 1", in_dst_rdy);
    else n_pass++;
    repeat (8) @(posedge clk);
    #1;
    n_checks++;
    if (got_q.size() !== 0) $display("FAIL abort_no_output: got %0d bytes expected 0", got_q.size());
    else n_pass++;
    cmd_q = '{8'h01, 8'h00, 8'h04, 8'h33};
    build_exp(8'h01, 4, 8'h33);
    clear_mon();
    send_frame(eof_c);
    wait_done(exp_q.size());
    d = first_diff();
    n_checks++;
    if (d >= 0) $display("FAIL after_abort_frame: byte %0d got %h expected %h", d, got_at(d), exp_at(d));
    else n_pass++;
  endtask

  task automatic test_reset_mid_frame();
    int eof_c, d, g, n_eof;
    cmd_q = '{8'h01, 8'h00, 8'h0A, 8'h50};
    clear_mon();
    send_frame(eof_c);
    g = 0;
    while (got_q.size() < 3 && g < 200) begin
      @(negedge clk); #2;
      g++;
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if ({in_dst_rdy, out_src_rdy, out_sof, out_eof, busy, out_data} !== 13'd0)
      $display("FAIL midreset_outputs: got %h expected 0", {in_dst_rdy, out_src_rdy, out_sof, out_eof, busy, out_data});
    else n_pass++;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if ({in_dst_rdy, busy} !== 2'b10) $display("FAIL midreset_idle: got %b expected 10", {in_dst_rdy, busy});
    else n_pass++;
    n_eof = 0;
    foreach (got_q[i]) if (got_q[i][8]) n_eof++;
    n_checks++;
    if (got_q.size() !== 3 || n_eof !== 0)
      $display("FAIL midreset_partial: got %0d bytes %0d eof expected 3 bytes 0 eof", got_q.size(), n_eof);
    else n_pass++;
    cmd_q = '{8'h01, 8'h00, 8'h03, 8'h60};
    build_exp(8'h01, 3, 8'h60);
    clear_mon();
    send_frame(eof_c);
    wait_done(exp_q.size());
    d = first_diff();
    n_checks++;
    if (d >= 0) $display("FAIL post_reset_frame: byte %0d got %h expected %h", d, got_at(d), exp_at(d));
    else n_pass++;
  endtask

`ifdef PATTERN_LFSR_EN
  task automatic test_lfsr();
    int eof_c, d;
    logic [9:0] w;
    cmd_q = '{8'h01, 8'h00, 8'h03, 8'h00};
    build_exp(8'h01, 3, 8'h00);
    clear_mon();
    send_frame(eof_c);
    wait_done(exp_q.size());
    w = got_at(0);
    n_checks++;
    if (w !== 10'h2FF) $display("FAIL lfsr_first: got %h expected 2ff", w);
    else n_pass++;
    d = first_diff();
    n_checks++;
    if (d >= 0) $display("FAIL lfsr_frame: byte %0d got %h expected %h", d, got_at(d), exp_at(d));
    else n_pass++;
  endtask
`endif

  task automatic test_random();
    int eof_c, d, len, extra, hold_tot, leak_tot;
    logic [7:0] op, seed;
    hold_tot = 0;
    leak_tot = 0;
    fc_mode  = 1;
    for (int it = 0; it < 12; it++) begin
      op    = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'h01;
      len   = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 30));
      seed  = 8'($urandom);
      extra = $urandom_range(0, 2);
      cmd_q = '{op, 8'(len >> 8), 8'(len), seed};
      repeat (extra) cmd_q.push_back(8'($urandom));
      build_exp(op, len, seed);
      clear_mon();
      send_frame(eof_c);
      wait_done(exp_q.size());
      d = first_diff();
      n_checks++;
      if (d >= 0) $display("FAIL random_frame%0d: byte %0d got %h expected %h", it, d, got_at(d), exp_at(d));
      else n_pass++;
      hold_tot += hold_err;
      leak_tot += rdy_leak;
    end
    fc_mode = 0; ren = 1'b1; out_dst_rdy = 1'b1;
    n_checks++;
    if (hold_tot !== 0 || leak_tot !== 0)
      $display("FAIL random_hold_rdy: got %0d hold %0d leak expected 0 0", hold_tot, leak_tot);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap_max();
    test_single_and_reject();
    test_backpressure();
    test_abort_then_valid();
    test_reset_mid_frame();
`ifdef PATTERN_LFSR_EN
    test_lfsr();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
